// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and width defaults for the instruction/data memory port arbiter.
// Holds the arbiter FSM state encoding and the XLEN/AW defaults used by every file.
package mem_arb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 32;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_D,
    BUSY_I,
    RESP_D,
    RESP_I
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory handshake signals around the arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int XLEN = mem_arb_pkg::XLEN_DEF,
  parameter int AW   = mem_arb_pkg::AW_DEF
);

  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_ack;
  logic [XLEN-1:0] if_rdata;

  logic            dm_req;
  logic            dm_we;
  logic [AW-1:0]   dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_ack;
  logic [XLEN-1:0] dm_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  logic            stall_F;
  logic            stall_M;
  logic            err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    output stall_F, stall_M, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_F, stall_M, err
  );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Watchdog for the arbiter's BUSY phase: counts enabled cycles, clears when idle.
// expired is high during the TIMEOUT-th consecutive enabled cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expired = en && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters; 3 cycles per access at zero wait.
// Requests are levels held until ack; data wins unless fetch was passed over STARVE_MAX times.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int AW         = AW_DEF,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e      state, state_nxt;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] resp_q;
  logic            err_q;
  logic [SW-1:0]   starve_cnt;
  logic            grant_d, grant_i;
  logic            busy, expired;

  assign busy = (state == BUSY_D) || (state == BUSY_I);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy),
    .en      (busy),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state)
      IDLE: begin
        // A fetch that has lost STARVE_MAX times in a row beats a pending data request.
        if (bus.dm_req && !(bus.if_req && starve_cnt == SW'(STARVE_MAX))) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (bus.if_req) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_D:  if (bus.mem_ack || expired) state_nxt = RESP_D;
      BUSY_I:  if (bus.mem_ack || expired) state_nxt = RESP_I;
      RESP_D:  state_nxt = IDLE;
      RESP_I:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      resp_q     <= '0;
      err_q      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;

      if (grant_d) begin
        addr_q     <= bus.dm_addr;
        we_q       <= bus.dm_we;
        wdata_q    <= bus.dm_wdata;
        starve_cnt <= !bus.if_req ? '0 :
                      (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + SW'(1);
      end else if (grant_i) begin
        addr_q     <= bus.if_addr;
        we_q       <= 1'b0;
        wdata_q    <= '0;
        starve_cnt <= '0;
      end

      // Stores and watchdog aborts both return zero data.
      if (busy && (bus.mem_ack || expired)) begin
        resp_q <= (bus.mem_ack && !we_q) ? bus.mem_rdata : '0;
      end
      err_q <= busy && !bus.mem_ack && expired;
    end
  end

  assign bus.mem_req   = busy;
  assign bus.mem_we    = busy && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.if_ack    = (state == RESP_I);
  assign bus.dm_ack    = (state == RESP_D);
  assign bus.if_rdata  = bus.if_ack ? resp_q : '0;
  assign bus.dm_rdata  = bus.dm_ack ? resp_q : '0;
  assign bus.err       = err_q;

  assign bus.stall_F   = bus.if_req && !bus.if_ack;
  assign bus.stall_M   = bus.dm_req && !bus.dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle table, corner sequences, then random traffic
// scored against a transaction-level model of the arbitration and memory rules.
module tb_mem_port_arbiter;

  localparam int          STARVE  = 4;
  localparam int          NROWS   = 18;
  localparam logic [31:0] IF_ADDR = 32'h0000_4000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.XLEN(32), .AW(32), .STARVE_MAX(STARVE), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dm_req, dm_we, if_req, mem_ack;
    logic [31:0] dm_addr, dm_wdata, mem_rdata;
    logic        e_mem_req, e_mem_we, e_dm_ack, e_if_ack, e_stall_f, e_stall_m;
    logic [31:0] e_addr, e_rdata;
  } vec_t;

  vec_t tbl [NROWS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired waiting for the DUT", name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.dm_req = 0; bus.if_req = 0; bus.dm_we = 0; bus.mem_ack = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.if_addr = '0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic new_dm();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'($urandom_range(0, 1));
    bus.dm_addr  = $urandom;
    bus.dm_wdata = $urandom;
  endtask

  task automatic new_if();
    bus.if_req  = 1'b1;
    bus.if_addr = $urandom;
  endtask

  // Random-phase model state
  int          starve_m, lat, age, w, n;
  logic        granting, busy_m, resp_m, own_d, idle_now, acked_d, acked_i;
  logic        t_we;
  logic [31:0] t_addr, t_wdata, exp_rd, rd;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.dm_req = 0; bus.if_req = 0; bus.dm_we = 0; bus.mem_ack = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.if_addr = '0; bus.mem_rdata = '0;

    // Reset values, before any clock edge
    #3;
    chk("reset_ctrl", {bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.err}, 0);
    chk("reset_bus", {bus.mem_addr, bus.mem_wdata}, 0);
    chk("reset_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
    do_reset();

    // Directed cycle table: load, data-vs-fetch tie, store
    tbl[0]  = '{1,0,0,0, 32'h200, 0, 0,                   0,0,0,0,0,1, 0, 0};
    tbl[1]  = '{1,0,0,0, 32'h200, 0, 0,                   1,0,0,0,0,1, 32'h200, 0};
    tbl[2]  = '{1,0,0,1, 32'h200, 0, 32'hDEAD_BEEF,       1,0,0,0,0,1, 32'h200, 0};
    tbl[3]  = '{1,0,0,0, 32'h200, 0, 0,                   0,0,1,0,0,0, 0, 32'hDEAD_BEEF};
    tbl[4]  = '{0,0,0,0, 0, 0, 0,                         0,0,0,0,0,0, 0, 0};
    tbl[5]  = '{1,0,1,0, 32'h300, 0, 0,                   0,0,0,0,1,1, 0, 0};
    tbl[6]  = '{1,0,1,1, 32'h300, 0, 32'h1111_2222,       1,0,0,0,1,1, 32'h300, 0};
    tbl[7]  = '{1,0,1,0, 32'h300, 0, 0,                   0,0,1,0,1,0, 0, 32'h1111_2222};
    tbl[8]  = '{0,0,1,0, 0, 0, 0,                         0,0,0,0,1,0, 0, 0};
    tbl[9]  = '{0,0,1,1, 0, 0, 32'hCAFE_0001,             1,0,0,0,1,0, IF_ADDR, 0};
    tbl[10] = '{0,0,1,0, 0, 0, 0,                         0,0,0,1,0,0, 0, 32'hCAFE_0001};
    tbl[11] = '{0,0,0,0, 0, 0, 0,                         0,0,0,0,0,0, 0, 0};
    tbl[12] = '{1,1,0,0, 32'h100, 32'h55, 0,              0,0,0,0,0,1, 0, 0};
    tbl[13] = '{1,1,0,0, 32'h100, 32'h55, 0,              1,1,0,0,0,1, 32'h100, 0};
    tbl[14] = '{1,1,0,0, 32'h100, 32'h55, 0,              1,1,0,0,0,1, 32'h100, 0};
    tbl[15] = '{1,1,0,1, 32'h100, 32'h55, 32'hFFFF_FFFF,  1,1,0,0,0,1, 32'h100, 0};
    tbl[16] = '{1,1,0,0, 32'h100, 32'h55, 0,              0,0,1,0,0,0, 0, 0};
    tbl[17] = '{0,0,0,0, 0, 0, 0,                         0,0,0,0,0,0, 0, 0};

    for (int r = 0; r < NROWS; r++) begin
      @(negedge clk);
      bus.dm_req = tbl[r].dm_req;   bus.dm_we = tbl[r].dm_we;
      bus.if_req = tbl[r].if_req;   bus.mem_ack = tbl[r].mem_ack;
      bus.dm_addr = tbl[r].dm_addr; bus.dm_wdata = tbl[r].dm_wdata;
      bus.mem_rdata = tbl[r].mem_rdata; bus.if_addr = IF_ADDR;
      #1;
      chk($sformatf("tbl%0d_mem_req", r), bus.mem_req, tbl[r].e_mem_req);
      chk($sformatf("tbl%0d_acks", r), {bus.dm_ack, bus.if_ack}, {tbl[r].e_dm_ack, tbl[r].e_if_ack});
      chk($sformatf("tbl%0d_stall", r), {bus.stall_F, bus.stall_M}, {tbl[r].e_stall_f, tbl[r].e_stall_m});
      if (tbl[r].e_mem_req) begin
        chk($sformatf("tbl%0d_mem_addr", r), bus.mem_addr, tbl[r].e_addr);
        chk($sformatf("tbl%0d_mem_we", r), bus.mem_we, tbl[r].e_mem_we);
        if (tbl[r].e_mem_we) chk($sformatf("tbl%0d_mem_wdata", r), bus.mem_wdata, tbl[r].dm_wdata);
      end
      if (tbl[r].e_dm_ack) chk($sformatf("tbl%0d_dm_rdata", r), bus.dm_rdata, tbl[r].e_rdata);
      if (tbl[r].e_if_ack) chk($sformatf("tbl%0d_if_rdata", r), bus.if_rdata, tbl[r].e_rdata);
      if (tbl[r].e_dm_ack || tbl[r].e_if_ack) chk($sformatf("tbl%0d_err", r), bus.err, 0);
    end

    // Starvation: both held, expect D D D D I D D D D I
    do_reset();
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h0000_0A00;
    bus.if_req = 1; bus.if_addr = IF_ADDR;
    for (int g = 0; g < 10; g++) begin
      w = 0;
      @(negedge clk);
      while (!bus.mem_req && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!bus.mem_req) begin
        miss("starve_grant");
        break;
      end
      chk($sformatf("starve_owner%0d", g), bus.mem_addr, (g % 5 == 4) ? IF_ADDR : 32'h0000_0A00);
      bus.mem_ack = 1; bus.mem_rdata = 32'(g);
      @(negedge clk);
      bus.mem_ack = 0;
      chk($sformatf("starve_ack%0d", g), {bus.dm_ack, bus.if_ack}, (g % 5 == 4) ? 2'b01 : 2'b10);
    end
    bus.dm_req = 0; bus.if_req = 0;

    // Watchdog: memory never answers
    do_reset();
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h0000_0B00; bus.mem_rdata = 32'h1234_5678;
    n = 0;
    @(negedge clk);
    while (bus.mem_req && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_busy_cycles", n, 255);
    chk("timeout_err", bus.err, 1);
    chk("timeout_dm_ack", bus.dm_ack, 1);
    chk("timeout_dm_rdata", bus.dm_rdata, 0);
    chk("timeout_mem_req", bus.mem_req, 0);
    bus.dm_req = 0;
    @(negedge clk);
    chk("timeout_err_clear", {bus.err, bus.dm_ack}, 0);

    // Reset in the middle of a fetch
    do_reset();
    bus.if_req = 1; bus.if_addr = IF_ADDR;
    @(negedge clk);
    chk("rstbusy_grant", bus.mem_req, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstbusy_async_mem_req", bus.mem_req, 0);
    chk("rstbusy_async_if_ack", bus.if_ack, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rstbusy_hold_no_ack", {bus.if_ack, bus.mem_req}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rstbusy_regrant", {bus.mem_req, bus.mem_addr}, {1'b1, IF_ADDR});
    bus.mem_ack = 1; bus.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.mem_ack = 0;
    chk("rstbusy_if_ack", bus.if_ack, 1);
    chk("rstbusy_if_rdata", bus.if_rdata, 32'h0BAD_F00D);
    bus.if_req = 0;

    // Random traffic against the transaction-level model
    do_reset();
    starve_m = 0; granting = 0; busy_m = 0; resp_m = 0; own_d = 0;
    lat = 1; age = 0; t_we = 0; t_addr = 0; t_wdata = 0; exp_rd = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      idle_now = 0; acked_d = 0; acked_i = 0;
      chk("rnd_stall", {bus.stall_F, bus.stall_M},
          {bus.if_req && !(resp_m && !own_d), bus.dm_req && !(resp_m && own_d)});
      if (resp_m) begin
        chk("rnd_ack", {bus.dm_ack, bus.if_ack}, {own_d, !own_d});
        chk("rnd_rdata", own_d ? bus.dm_rdata : bus.if_rdata, exp_rd);
        chk("rnd_resp_flags", {bus.err, bus.mem_req}, 0);
        acked_d = own_d; acked_i = !own_d;
        resp_m = 0;
      end else if (granting && bus.mem_req) begin
        own_d = bus.dm_req && !(bus.if_req && starve_m == STARVE);
        if (own_d) starve_m = bus.if_req ? ((starve_m < STARVE) ? starve_m + 1 : STARVE) : 0;
        else starve_m = 0;
        t_addr = own_d ? bus.dm_addr : bus.if_addr;
        t_we = own_d && bus.dm_we;
        t_wdata = bus.dm_wdata;
        chk("rnd_grant_bus", {bus.mem_we, bus.mem_addr}, {t_we, t_addr});
        if (t_we) chk("rnd_grant_wdata", bus.mem_wdata, t_wdata);
        granting = 0; busy_m = 1; age = 1; lat = $urandom_range(1, 4);
      end else if (granting) begin
        miss("rnd_grant");
        granting = 0;
        idle_now = 1;
      end else if (busy_m) begin
        chk("rnd_busy_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.dm_ack, bus.if_ack},
            {1'b1, t_we, t_addr, 2'b00});
        if (t_we) chk("rnd_busy_wdata", bus.mem_wdata, t_wdata);
      end else begin
        chk("rnd_idle", {bus.mem_req, bus.dm_ack, bus.if_ack}, 0);
        idle_now = 1;
      end

      // Memory side
      rd = $urandom;
      bus.mem_rdata = rd;
      if (busy_m) begin
        if (age == lat) begin
          bus.mem_ack = 1;
          exp_rd = t_we ? 32'h0 : rd;
          busy_m = 0;
          resp_m = 1;
        end else begin
          bus.mem_ack = 0;
          age++;
        end
      end else begin
        bus.mem_ack = ($urandom_range(0, 3) == 0);
      end

      // Requester side
      if (acked_d) begin
        if ($urandom_range(0, 1) == 1) new_dm();
        else bus.dm_req = 0;
      end else if (!bus.dm_req && $urandom_range(0, 2) == 0) new_dm();
      if (acked_i) begin
        if ($urandom_range(0, 1) == 1) new_if();
        else bus.if_req = 0;
      end else if (!bus.if_req && $urandom_range(0, 2) == 0) new_if();

      granting = idle_now && (bus.dm_req || bus.if_req);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_bound: simulation did not complete in time");
    $fatal(1, "global time bound reached");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data width; AW, default 32, address width; STARVE_MAX, default 4, consecutive data grants before a pending fetch is forced; TIMEOUT, default 255, BUSY cycles without mem_ack before abort.
REQ-002 The ports SHALL be as follows, one per line: name, direction, width, meaning.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 if_req  input  1  fetch request; level, held until if_ack.
REQ-006 if_addr  input  AW  fetch address.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  XLEN  fetched instruction; valid while if_ack=1.
REQ-009 dm_req  input  1  MEM-stage data request; level, held until dm_ack.
REQ-010 dm_we  input  1  1=store, 0=load.
REQ-011 dm_addr  input  AW  data address.
REQ-012 dm_wdata  input  XLEN  store data.
REQ-013 dm_ack  output  1  one-cycle data completion pulse.
REQ-014 dm_rdata  output  XLEN  load data; valid while dm_ack=1; 0 for stores.
REQ-015 mem_req  output  1  request to the shared memory port.
REQ-016 mem_we  output  1  write enable to memory.
REQ-017 mem_addr  output  AW  memory address.
REQ-018 mem_wdata  output  XLEN  memory write data.
REQ-019 mem_rdata  input  XLEN  memory read data; valid with mem_ack.
REQ-020 mem_ack  input  1  memory completion; any latency of 1 cycle or more.
REQ-021 stall_F  output  1  to hazard logic: if_req & ~if_ack; combinational.
REQ-022 stall_M  output  1  to hazard logic: dm_req & ~dm_ack; combinational.
REQ-023 err  output  1  timeout flag; pulses together with the aborted ack.

Function
REQ-024 The FSM SHALL have the states IDLE, BUSY_D, BUSY_I, RESP_D and RESP_I.
REQ-025 In IDLE, the block SHALL grant data when dm_req=1, unless if_req=1 and starve_cnt==STARVE_MAX, in which case it SHALL grant fetch; with only if_req=1 it SHALL grant fetch; with no request it SHALL stay in IDLE.
REQ-026 The grant edge SHALL latch the address, we and wdata into internal registers and enter BUSY_x; request inputs SHALL be ignored outside IDLE.
REQ-027 In BUSY_x, mem_req SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL be held stable from the latched registers.
REQ-028 mem_we SHALL be 0 for fetch.
REQ-029 In BUSY_x, mem_ack=1 SHALL capture mem_rdata into the response register and move to RESP_x.
REQ-030 In RESP_x, the block SHALL assert the owner's ack for exactly one cycle, drive mem_req=0 and return unconditionally to IDLE.
REQ-031 A zero-wait memory SHALL give one transaction per 3 cycles (grant, BUSY, RESP).
REQ-032 Requester contract: in the cycle after its ack, a requester SHALL either deassert req or present a new request; the IDLE cycle guarantees no duplicate grant.
REQ-033 starve_cnt SHALL increment, saturating at STARVE_MAX, on a data grant while if_req=1; it SHALL clear on a fetch grant and on a data grant with if_req=0.
REQ-034 The watchdog SHALL count BUSY cycles; at TIMEOUT without mem_ack, it SHALL move to RESP_x with response data 0 and err=1.
REQ-035 mem_ack SHALL be ignored in IDLE and RESP_x.
REQ-036 A store SHALL return dm_rdata=0.

Reset
REQ-037 rst=1 SHALL force, without waiting for a clock edge, state IDLE, starve_cnt 0, the watchdog 0, and every output and response register 0; an in-flight transaction SHALL be abandoned with mem_req dropping immediately and no ack issued.

Structure
REQ-038 The package mem_arb_pkg SHALL hold the state enum and the XLEN and AW defaults.
REQ-039 The watchdog SHALL be the sub-module mem_timeout_ctr, with inputs clk, rst, clr and en and output expired.

Verification
REQ-040 Load with 2-cycle mem_ack, rdata 0xDEADBEEF: mem_req high for 2 cycles, then dm_ack and dm_rdata=0xDEADBEEF for 1 cycle.
REQ-041 dm_req and if_req together at IDLE: data is served first; fetch is granted on the IDLE after RESP_D.
REQ-042 dm_req held continuously with if_req=1: the 5th grant is a fetch; starve_cnt returns to 0.
REQ-043 mem_ack never asserts: after 255 BUSY cycles, err=1 together with the ack, rdata=0, mem_req=0.
REQ-044 rst pulsed during BUSY_I: mem_req=0 asynchronously, no if_ack, and a grant occurs on the first IDLE after release.
REQ-045 Store dm_addr 0x100, dm_wdata 0x55: mem_we=1, mem_addr=0x100 and mem_wdata=0x55 stable until mem_ack; dm_rdata=0.
